// File: rtl/sdio_cmd_pkg.sv
// Shared definitions for the SD/SDIO command-line engine: response types,
// status bit positions and the command FSM state encoding.
package sdio_cmd_pkg;

  localparam logic [2:0] RSP_NONE      = 3'd0;
  localparam logic [2:0] RSP_R48       = 3'd1;
  localparam logic [2:0] RSP_R48_NOCRC = 3'd2;
  localparam logic [2:0] RSP_R136      = 3'd3;
  localparam logic [2:0] RSP_R48_BUSY  = 3'd4;

  localparam int ST_RSP_TO  = 0;
  localparam int ST_DIR     = 1;
  localparam int ST_BUSY_TO = 2;
  localparam int ST_CRC     = 3;
  localparam int ST_IDX     = 4;
  localparam int ST_END     = 5;

  typedef enum logic [3:0] {
    S_IDLE, S_TX_START, S_TX_DIR, S_TX_SHIFT, S_TX_CRC, S_TX_STOP,
    S_RX_WAIT, S_RX_DIR, S_RX_SHIFT, S_RX_CRC, S_RX_END,
    S_WAIT_BUSY, S_WAIT_NCC
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1). Either absorbs a bit (en) or shifts the
// finished remainder out MSB first (shift); clear has priority.
module sdio_crc7 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_shift,
  input  logic i_bit,
  output logic o_msb
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_msb = r_crc[6];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ ({7{w_fb}} & 7'h09);
    end else if (i_shift) begin
      r_crc <= {r_crc[5:0], 1'b0};
    end
  end

endmodule

// File: rtl/sdio_cmd_ctrl.sv
// SD/SDIO CMD-line engine: sends a 48-bit command with CRC7, receives and
// checks the R48/R136 response, waits out R1b busy and the N_CC gap.
module sdio_cmd_ctrl
  import sdio_cmd_pkg::*;
#(
  parameter int RSP_TIMEOUT = 64,
  parameter int NCC_CYCLES  = 8,
  parameter int BUSY_W      = 16,
  parameter int CHECK_IDX   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_stat_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [5:0]        cmd_op_i,
  input  logic [31:0]       cmd_arg_i,
  input  logic [2:0]        cmd_rsp_type_i,
  input  logic [BUSY_W-1:0] busy_timeout_i,
  input  logic              busy_i,
  output logic [127:0]      rsp_data_o,
  output logic              rsp_valid_o,
  output logic [7:0]        status_o,
  output logic              start_read_o,
  output logic              start_write_o,
  output logic              eot_o,
  output logic              sdclk_en_o,
  input  logic              sdcmd_i,
  output logic              sdcmd_o,
  output logic              sdcmd_oen_o
);

  localparam int CW = $clog2(max3(RSP_TIMEOUT, NCC_CYCLES, 136) + 1);

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [BUSY_W-1:0] r_bcnt, r_busy_lim;
  logic [5:0]        r_op;
  logic [2:0]        r_type;
  logic [37:0]       r_tx_sr;
  logic [127:0]      r_rsp;
  logic [5:0]        r_status;
  logic              r_eot, r_sdcmd, r_oen;
  logic              w_tx_oe, w_tx_bit;
  logic              w_crc_clr, w_crc_en, w_crc_shift, w_crc_bit, w_crc_msb;
  logic              w_r136, w_rx_skip;
  logic [CW-1:0]     w_rx_last;

  assign w_r136    = (r_type == RSP_R136);
  assign w_rx_last = w_r136 ? CW'(125) : CW'(37);
  // R2 carries 6 reserved bits ahead of the CID; they are neither stored nor CRC'd
  assign w_rx_skip = w_r136 && (r_cnt < CW'(6));

  sdio_crc7 u_crc (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_shift(w_crc_shift),
    .i_bit  (w_crc_bit),
    .o_msb  (w_crc_msb)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_oe      = 1'b0;
    w_tx_bit     = 1'b1;
    w_crc_clr    = 1'b0;
    w_crc_en     = 1'b0;
    w_crc_shift  = 1'b0;
    w_crc_bit    = 1'b0;
    case (r_state)
      S_IDLE:     if (cmd_valid_i) w_state_next = S_TX_START;
      S_TX_START: begin
        w_tx_oe = 1'b1; w_tx_bit = 1'b0; w_crc_clr = 1'b1;
        w_state_next = S_TX_DIR;
      end
      S_TX_DIR: begin
        w_tx_oe = 1'b1; w_crc_en = 1'b1; w_crc_bit = 1'b1;
        w_state_next = S_TX_SHIFT;
      end
      S_TX_SHIFT: begin
        w_tx_oe = 1'b1; w_tx_bit = r_tx_sr[37];
        w_crc_en = 1'b1; w_crc_bit = r_tx_sr[37];
        if (r_cnt == CW'(37)) w_state_next = S_TX_CRC;
      end
      S_TX_CRC: begin
        w_tx_oe = 1'b1; w_tx_bit = w_crc_msb; w_crc_shift = 1'b1;
        if (r_cnt == CW'(6)) w_state_next = S_TX_STOP;
      end
      S_TX_STOP: begin
        w_tx_oe = 1'b1;
        w_state_next = (r_type == RSP_NONE) ? S_WAIT_NCC : S_RX_WAIT;
      end
      S_RX_WAIT: begin
        if (!sdcmd_i) w_state_next = S_RX_DIR;
        else if (r_cnt == CW'(RSP_TIMEOUT - 1)) w_state_next = S_WAIT_NCC;
      end
      S_RX_DIR: begin
        // start and dir bits are both 0, so a cleared CRC already covers them
        w_crc_clr = 1'b1;
        w_state_next = sdcmd_i ? S_WAIT_NCC : S_RX_SHIFT;
      end
      S_RX_SHIFT: begin
        w_crc_en = !w_rx_skip; w_crc_bit = sdcmd_i;
        if (r_cnt == w_rx_last) w_state_next = S_RX_CRC;
      end
      S_RX_CRC: begin
        w_crc_shift = 1'b1;
        if (r_cnt == CW'(6)) w_state_next = S_RX_END;
      end
      S_RX_END:    w_state_next = (r_type == RSP_R48_BUSY) ? S_WAIT_BUSY : S_WAIT_NCC;
      S_WAIT_BUSY: if (!busy_i || (r_bcnt == r_busy_lim)) w_state_next = S_WAIT_NCC;
      S_WAIT_NCC:  if (r_cnt == CW'(NCC_CYCLES - 1)) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
    if (clr_stat_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0; r_bcnt <= '0; r_busy_lim <= '0; r_op <= '0; r_type <= '0;
      r_tx_sr <= '0; r_rsp <= '0; r_status <= '0; r_eot <= 1'b0;
    end else begin
      r_eot <= 1'b0;
      if (w_state_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1)        r_cnt <= r_cnt + 1'b1;
      if (r_state != S_WAIT_BUSY)  r_bcnt <= '0;
      else if (r_bcnt != '1)       r_bcnt <= r_bcnt + 1'b1;
      if (clr_stat_i) begin
        r_status <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (cmd_valid_i) begin
            r_op <= cmd_op_i; r_type <= cmd_rsp_type_i; r_busy_lim <= busy_timeout_i;
            r_tx_sr <= {cmd_op_i, cmd_arg_i}; r_rsp <= '0; r_status <= '0;
          end
          S_TX_SHIFT: r_tx_sr <= {r_tx_sr[36:0], 1'b0};
          S_RX_WAIT:  if (sdcmd_i && (r_cnt == CW'(RSP_TIMEOUT - 1))) r_status[ST_RSP_TO] <= 1'b1;
          S_RX_DIR:   if (sdcmd_i) r_status[ST_DIR] <= 1'b1;
          S_RX_SHIFT: if (!w_rx_skip) r_rsp <= {r_rsp[126:0], sdcmd_i};
          S_RX_CRC: begin
            if (w_r136) r_rsp <= {r_rsp[126:0], sdcmd_i};
            if ((r_type != RSP_R48_NOCRC) && (sdcmd_i != w_crc_msb)) r_status[ST_CRC] <= 1'b1;
          end
          S_RX_END: begin
            if (w_r136) r_rsp <= {r_rsp[126:0], sdcmd_i};
            if (!sdcmd_i) r_status[ST_END] <= 1'b1;
            if ((CHECK_IDX != 0) && ((r_type == RSP_R48) || (r_type == RSP_R48_BUSY)) &&
                (r_rsp[37:32] != r_op)) r_status[ST_IDX] <= 1'b1;
          end
          S_WAIT_BUSY: if (busy_i && (r_bcnt == r_busy_lim)) r_status[ST_BUSY_TO] <= 1'b1;
          S_WAIT_NCC:  if (r_cnt == CW'(NCC_CYCLES - 1)) r_eot <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // CMD line changes half a cycle after the state so the card sees it stable on rising edges
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_sdcmd <= 1'b1;
      r_oen   <= 1'b1;
    end else begin
      r_sdcmd <= w_tx_bit;
      r_oen   <= !w_tx_oe;
    end
  end

  assign cmd_ready_o   = (r_state == S_IDLE) && !clr_stat_i;
  assign start_read_o  = (r_state == S_TX_STOP);
  assign sdclk_en_o    = (r_state != S_IDLE);
  assign eot_o         = r_eot;
  assign rsp_valid_o   = r_eot;
  assign start_write_o = r_eot;
  assign rsp_data_o    = r_rsp;
  assign status_o      = {2'b00, r_status};
  assign sdcmd_o       = r_sdcmd;
  assign sdcmd_oen_o   = r_oen;

endmodule

// File: tb/tb_sdio_cmd_ctrl.sv
// Directed bench for sdio_cmd_ctrl: plays the card side of the CMD line and
// checks frames, responses, status bits and completion timing.
module tb_sdio_cmd_ctrl;

  logic         clk = 1'b0;
  logic         rst_i, clr_stat_i, cmd_valid_i, cmd_ready_o;
  logic [5:0]   cmd_op_i;
  logic [31:0]  cmd_arg_i;
  logic [2:0]   cmd_rsp_type_i;
  logic [15:0]  busy_timeout_i;
  logic         busy_i;
  logic [127:0] rsp_data_o;
  logic         rsp_valid_o, start_read_o, start_write_o, eot_o, sdclk_en_o;
  logic [7:0]   status_o;
  logic         sdcmd_i, sdcmd_o, sdcmd_oen_o;

  always #5 clk = ~clk;

  sdio_cmd_ctrl #(.RSP_TIMEOUT(64), .NCC_CYCLES(8), .BUSY_W(16), .CHECK_IDX(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_stat_i(clr_stat_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i), .cmd_rsp_type_i(cmd_rsp_type_i),
    .busy_timeout_i(busy_timeout_i), .busy_i(busy_i),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .status_o(status_o),
    .start_read_o(start_read_o), .start_write_o(start_write_o), .eot_o(eot_o),
    .sdclk_en_o(sdclk_en_o), .sdcmd_i(sdcmd_i), .sdcmd_o(sdcmd_o), .sdcmd_oen_o(sdcmd_oen_o)
  );

  int           n_checks = 0, n_errors = 0;
  int           n_edge, eot_lat, to_edge, bto_edge, n_eot, pulse_bad;
  logic [127:0] rsp_at_eot;
  logic [7:0]   st_at_eot;

  task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] mk_r48(input logic [5:0] idx, input logic [31:0] arg,
                                         input logic [6:0] flip, input logic dir);
    logic [39:0] head;
    head = {1'b0, dir, idx, arg};
    return 136'({head, crc7(128'(head), 40) ^ flip, 1'b1});
  endfunction

  // One clock: land 1 time unit after the rising edge and record events
  task automatic tick();
    @(posedge clk);
    #1;
    n_edge++;
    if (eot_o) begin
      n_eot++;
      if (eot_lat < 0) begin
        eot_lat    = n_edge + 1;
        rsp_at_eot = rsp_data_o;
        st_at_eot  = status_o;
      end
    end
    if ((rsp_valid_o !== eot_o) || (start_write_o !== eot_o)) pulse_bad++;
    if (status_o[0] && (to_edge < 0))  to_edge  = n_edge;
    if (status_o[2] && (bto_edge < 0)) bto_edge = n_edge;
  endtask

  task automatic do_txn(input string tag, input logic [5:0] op, input logic [31:0] arg,
                        input logic [2:0] typ, input logic [15:0] blim,
                        input logic [135:0] rsp, input int rsp_len, input int busy_len,
                        output logic [47:0] frame, output int sr_idx, output int oen_bad);
    frame = '0; sr_idx = -1; oen_bad = 0;
    eot_lat = -1; to_edge = -1; bto_edge = -1; n_eot = 0; pulse_bad = 0;
    cmd_op_i = op; cmd_arg_i = arg; cmd_rsp_type_i = typ; busy_timeout_i = blim;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    n_edge = 0;
    for (int j = 0; j < 48; j++) begin
      tick();
      frame[47-j] = sdcmd_o;
      if (sdcmd_oen_o !== 1'b0) oen_bad++;
      if (start_read_o) sr_idx = (sr_idx < 0) ? j : 1000;
    end
    if (rsp_len > 0) begin
      repeat (4) tick();
      for (int b = rsp_len - 1; b >= 0; b--) begin
        sdcmd_i = rsp[b];
        if ((b == 0) && (busy_len > 0)) busy_i = 1'b1;
        tick();
      end
      sdcmd_i = 1'b1;
      repeat (busy_len) tick();
      busy_i = 1'b0;
    end
    for (int g = 0; (g < 3000) && (eot_lat < 0); g++) tick();
    repeat (2) tick();
    $display("txn %s op=%0d type=%0d frame=%h status=%h rsp=%h eot_at=%0d",
             tag, op, typ, frame, st_at_eot, rsp_at_eot, eot_lat);
  endtask

  logic [47:0]  fr;
  int           sri, oenb;
  logic [119:0] cid_pay;
  logic [127:0] cid;
  logic [31:0]  ocr;
  logic [39:0]  r3_head;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; clr_stat_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_arg_i = '0;
    cmd_rsp_type_i = '0; busy_timeout_i = '0; busy_i = 1'b0; sdcmd_i = 1'b1;
    n_edge = 0; eot_lat = -1; to_edge = -1; bto_edge = -1; n_eot = 0; pulse_bad = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    tick();
    check_val("rst_ready", 136'(cmd_ready_o), 136'(1));
    check_val("rst_status", 136'(status_o), 136'(0));
    check_val("rst_rsp", 136'(rsp_data_o), 136'(0));
    check_val("rst_lines", 136'({sdcmd_o, sdcmd_oen_o, sdclk_en_o}), 136'(3'b110));
    check_val("rst_pulses", 136'({eot_o, rsp_valid_o, start_read_o, start_write_o}), 136'(0));
    $display("txn reset done");

    do_txn("CMD0", 6'd0, 32'h0, 3'd0, 16'd0, '0, 0, 0, fr, sri, oenb);
    check_val("cmd0_frame", 136'(fr), 136'(48'h400000000095));
    check_val("cmd0_start_read_idx", 136'(sri), 136'(46));
    check_val("cmd0_oen_driven", 136'(oenb), 136'(0));
    check_val("cmd0_eot_latency", 136'(eot_lat), 136'(57));
    check_val("cmd0_status", 136'(st_at_eot), 136'(0));
    check_val("cmd0_eot_count", 136'(n_eot), 136'(1));
    check_val("cmd0_pulse_align", 136'(pulse_bad), 136'(0));

    do_txn("CMD8", 6'd8, 32'h1AA, 3'd1, 16'd0, mk_r48(6'd8, 32'h1AA, 7'h00, 1'b0), 48, 0, fr, sri, oenb);
    check_val("cmd8_frame", 136'(fr), 136'(48'h48000001AA87));
    check_val("cmd8_rsp", 136'(rsp_at_eot), 136'(40'h08000001AA));
    check_val("cmd8_status", 136'(st_at_eot), 136'(0));

    do_txn("CMD8_badcrc", 6'd8, 32'h1AA, 3'd1, 16'd0, mk_r48(6'd8, 32'h1AA, 7'h01, 1'b0), 48, 0, fr, sri, oenb);
    check_val("cmd8_badcrc_status", 136'(st_at_eot), 136'(8'h08));
    check_val("cmd8_badcrc_eot", 136'(eot_lat > 0), 136'(1));

    do_txn("CMD8_badidx", 6'd8, 32'h1AA, 3'd1, 16'd0, mk_r48(6'd9, 32'h1AA, 7'h00, 1'b0), 48, 0, fr, sri, oenb);
    check_val("cmd8_badidx_status", 136'(st_at_eot), 136'(8'h10));

    do_txn("CMD8_baddir", 6'd8, 32'h1AA, 3'd1, 16'd0, mk_r48(6'd8, 32'h1AA, 7'h00, 1'b1), 48, 0, fr, sri, oenb);
    check_val("cmd8_baddir_status", 136'(st_at_eot), 136'(8'h02));

    do_txn("CMD55_noreply", 6'd55, 32'h0, 3'd1, 16'd0, '0, 0, 0, fr, sri, oenb);
    check_val("timeout_edge", 136'(to_edge), 136'(48 + 64));
    check_val("timeout_eot_latency", 136'(eot_lat), 136'(48 + 64 + 8 + 1));
    check_val("timeout_status", 136'(st_at_eot), 136'(8'h01));

    do_txn("CMD7_busy40", 6'd7, 32'h12340000, 3'd4, 16'd100, mk_r48(6'd7, 32'h12340000, 7'h00, 1'b0), 48, 40, fr, sri, oenb);
    check_val("busy40_status", 136'(st_at_eot), 136'(0));

    do_txn("CMD7_busy200", 6'd7, 32'h12340000, 3'd4, 16'd100, mk_r48(6'd7, 32'h12340000, 7'h00, 1'b0), 48, 200, fr, sri, oenb);
    check_val("busy200_status", 136'(st_at_eot), 136'(8'h04));
    check_val("busy200_timeout_edge", 136'(bto_edge), 136'(201));
    check_val("busy200_eot_latency", 136'(eot_lat), 136'(210));

    do_txn("CMD7_lim0", 6'd7, 32'h12340000, 3'd4, 16'd0, mk_r48(6'd7, 32'h12340000, 7'h00, 1'b0), 48, 5, fr, sri, oenb);
    check_val("lim0_status", 136'(st_at_eot), 136'(8'h04));
    check_val("lim0_timeout_edge", 136'(bto_edge), 136'(101));

    cid_pay = 120'h035344534430328012345678013765;
    cid = {cid_pay, crc7({8'h00, cid_pay}, 120), 1'b1};
    do_txn("CMD2_R2", 6'd2, 32'h0, 3'd3, 16'd0, {2'b00, 6'h3F, cid}, 136, 0, fr, sri, oenb);
    check_val("r2_rsp", 136'(rsp_at_eot), 136'(cid));
    check_val("r2_status", 136'(st_at_eot), 136'(0));

    ocr = 32'h80FF8000;
    r3_head = {2'b00, 6'h3F, ocr};
    do_txn("ACMD41_R3", 6'd41, 32'h40FF8000, 3'd2, 16'd0,
           136'({r3_head, ~crc7(128'(r3_head), 40), 1'b1}), 48, 0, fr, sri, oenb);
    check_val("r3_status", 136'(st_at_eot), 136'(0));
    check_val("r3_rsp", 136'(rsp_at_eot), 136'({6'h3F, ocr}));

    // Abort mid TX_SHIFT with a new command pending
    eot_lat = -1; n_eot = 0; pulse_bad = 0;
    cmd_op_i = 6'd0; cmd_arg_i = 32'h0; cmd_rsp_type_i = 3'd0; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (10) tick();
    clr_stat_i = 1'b1; cmd_valid_i = 1'b1;
    #1;
    check_val("clr_ready_low", 136'(cmd_ready_o), 136'(0));
    tick();
    check_val("clr_idle_next", 136'(sdclk_en_o), 136'(0));
    @(negedge clk);
    #1;
    check_val("clr_line_released", 136'({sdcmd_oen_o, sdcmd_o}), 136'(2'b11));
    repeat (3) tick();
    check_val("clr_not_accepted", 136'(sdclk_en_o), 136'(0));
    clr_stat_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    n_edge = 0;
    check_val("clr_accept_after", 136'(sdclk_en_o), 136'(1));
    for (int g = 0; (g < 3000) && (eot_lat < 0); g++) tick();
    repeat (2) tick();
    check_val("clr_eot_latency", 136'(eot_lat), 136'(57));
    check_val("clr_eot_count", 136'(n_eot), 136'(1));
    $display("txn clr_abort eot_at=%0d eots=%0d", eot_lat, n_eot);

    // Reset in the middle of a transfer
    cmd_op_i = 6'd8; cmd_arg_i = 32'h1AA; cmd_rsp_type_i = 3'd1; cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (20) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_val("midrst_idle", 136'({cmd_ready_o, sdclk_en_o}), 136'(2'b10));
    check_val("midrst_status", 136'(status_o), 136'(0));
    @(negedge clk);
    #1;
    check_val("midrst_line", 136'({sdcmd_oen_o, sdcmd_o}), 136'(2'b11));
    $display("txn mid_reset ready=%0d oen=%0d", cmd_ready_o, sdcmd_oen_o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
